// File: rtl/mram_pkg.sv
// mram_pkg: shared definitions for the Mram round-robin arbiter.
//   - default geometry (address width, word width, depth)
//   - arbiter FSM state encoding
//   - client identifiers used for round-robin bookkeeping
//   - helper that produces the power-on fill pattern
package mram_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  localparam logic CLI_A = 1'b0;
  localparam logic CLI_B = 1'b1;

  // Fill pattern for word k is 2*k; the caller truncates to the word width,
  // which supplies the modulo 2**WORD_W.
  function automatic int unsigned init_word(input int unsigned k);
    return k << 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: pure two-way round-robin picker.
//   req  [1:0] in   request vector, bit 0 = client A, bit 1 = client B
//   last       in   id of the client granted most recently (CLI_A / CLI_B)
//   gnt  [1:0] out  one-hot grant (or zero when nothing requests)
module rr_arb2
  import mram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the client that did not win last time gets the slot.
    if (req == 2'b11) begin
      gnt = (last == CLI_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mram_arbiter.sv
// mram_arbiter: two-requester round-robin controller for the single-port
// word RAM. It owns the RAM pins and serialises client A / client B accesses,
// returning read data and a one-cycle ack per completed access.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata client A request, direction, address, write data
//   a_ack                     client A one-cycle completion pulse
//   b_*                       same for client B
//   rdata                     read data of the acked access (valid with ack)
//   init_done                 RAM ready for client traffic
//   mem_addr/mem_din/mem_wr/mem_cs/mem_rd  registered RAM pins
//   mem_dout                  RAM combinational read data
//
// Optional feature: define MRAM_ARB_INIT_EN to fill the RAM with the pattern
// word[k] = 2*k after every reset before client traffic is admitted.
module mram_arbiter
  import mram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WORD_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WORD_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [WORD_W-1:0] rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  output logic              mem_wr,
  output logic              mem_cs,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_dout
);

  // The fill counter walks the whole address span, so the depth has to match it.
  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("mram_arbiter: DEPTH must equal 2**ADDR_W");
  end

`ifdef MRAM_ARB_INIT_EN
  localparam arb_state_t RESET_STATE = ST_INIT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`else
  localparam arb_state_t RESET_STATE = ST_IDLE;
`endif

  arb_state_t        state_reg, state_next;
  logic              last_reg, last_next;     // client granted most recently
  logic              owner_reg, owner_next;   // client owning the access in flight
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] din_reg, din_next;
  logic              wr_reg, wr_next;
  logic              cs_reg, cs_next;
  logic              rd_reg, rd_next;
  logic [WORD_W-1:0] rdata_reg, rdata_next;
  logic              a_ack_reg, a_ack_next;
  logic              b_ack_reg, b_ack_next;
  logic [1:0]        gnt;

`ifdef MRAM_ARB_INIT_EN
  logic [ADDR_W-1:0] init_cnt_reg, init_cnt_next;
  logic              init_done_reg, init_done_next;
`endif

  rr_arb2 u_rr (
    .req  ({b_req, a_req}),
    .last (last_reg),
    .gnt  (gnt)
  );

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    din_next   = din_reg;
    wr_next    = wr_reg;
    cs_next    = cs_reg;
    rd_next    = rd_reg;
    rdata_next = rdata_reg;
    a_ack_next = 1'b0;
    b_ack_next = 1'b0;
`ifdef MRAM_ARB_INIT_EN
    init_cnt_next  = init_cnt_reg;
    init_done_next = init_done_reg;
`endif

    unique case (state_reg)
      ST_INIT: begin
`ifdef MRAM_ARB_INIT_EN
        // One fill word per cycle; the RAM captures it on the following edge.
        addr_next     = init_cnt_reg;
        din_next      = WORD_W'(init_word(32'(init_cnt_reg)));
        wr_next       = 1'b1;
        cs_next       = 1'b1;
        rd_next       = 1'b0;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == LAST_ADDR) begin
          state_next     = ST_IDLE;
          init_done_next = 1'b1;
        end
`else
        state_next = ST_IDLE;
`endif
      end

      ST_IDLE: begin
        cs_next = 1'b0;
        wr_next = 1'b0;
        rd_next = 1'b0;
        if (gnt != 2'b00) begin
          // gnt is one-hot here; bit 1 set means client B won.
          owner_next = gnt[1] ? CLI_B : CLI_A;
          last_next  = gnt[1] ? CLI_B : CLI_A;
          addr_next  = gnt[1] ? b_addr  : a_addr;
          din_next   = gnt[1] ? b_wdata : a_wdata;
          wr_next    = gnt[1] ? b_we    : a_we;
          rd_next    = gnt[1] ? ~b_we   : ~a_we;
          cs_next    = 1'b1;
          state_next = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // RAM read is combinational, so its data is valid while the pins are held.
        if (!wr_reg) begin
          rdata_next = mem_dout;
        end
        wr_next    = 1'b0;
        rd_next    = 1'b0;
        cs_next    = 1'b0;
        state_next = ST_ACK;
      end

      ST_ACK: begin
        a_ack_next = (owner_reg == CLI_A);
        b_ack_next = (owner_reg == CLI_B);
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RESET_STATE;
      last_reg  <= CLI_B;
      owner_reg <= CLI_A;
      addr_reg  <= '0;
      din_reg   <= '0;
      wr_reg    <= 1'b0;
      cs_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      rdata_reg <= '0;
      a_ack_reg <= 1'b0;
      b_ack_reg <= 1'b0;
`ifdef MRAM_ARB_INIT_EN
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      wr_reg    <= wr_next;
      cs_reg    <= cs_next;
      rd_reg    <= rd_next;
      rdata_reg <= rdata_next;
      a_ack_reg <= a_ack_next;
      b_ack_reg <= b_ack_next;
`ifdef MRAM_ARB_INIT_EN
      init_cnt_reg  <= init_cnt_next;
      init_done_reg <= init_done_next;
`endif
    end
  end

  assign a_ack    = a_ack_reg;
  assign b_ack    = b_ack_reg;
  assign rdata    = rdata_reg;
  assign mem_addr = addr_reg;
  assign mem_din  = din_reg;
  assign mem_wr   = wr_reg;
  assign mem_cs   = cs_reg;
  assign mem_rd   = rd_reg;
`ifdef MRAM_ARB_INIT_EN
  assign init_done = init_done_reg;
`else
  assign init_done = 1'b1;
`endif

endmodule
